// File: rtl/wiener_block_stats_ctrl_mc.sv
// Block-statistics sequencer for a multi-channel Wiener filter: walks the pixel
// shift chain one block at a time, collects per-channel mean/variance handshakes, then flushes.
module wiener_block_stats_ctrl_mc #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64,
  parameter int NUM_CH        = 3,
  parameter int CNT_W         = $clog2(TOTAL_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_of_frame,
  input  logic              pixel_valid,
  input  logic [31:0]       blocks_per_frame,
  input  logic [NUM_CH-1:0] mean_ready,
  input  logic [NUM_CH-1:0] variance_ready,
  output logic              shift_en_1,
  output logic              shift_en_2,
  output logic [NUM_CH-1:0] shift_en_mean,
  output logic              shift_reg_rst_n,
  output logic              variance_start_of_data,
  output logic [31:0]       block_idx,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun_err
);

  if (DATA_WIDTH < 1 || TOTAL_SAMPLES < 2 || (TOTAL_SAMPLES & (TOTAL_SAMPLES - 1)) != 0 ||
      NUM_CH < 1 || NUM_CH > 8) begin : g_param_check
    $error("wiener_block_stats_ctrl_mc: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, READ_BLOCK, WAIT_STATS, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_SAMPLES - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] mean_seen;
  logic [NUM_CH-1:0] var_seen;
  logic [31:0]       bpf_q;

  logic accept, clear_all, all_means, last_block, last_sample, flush_shift;

  // An accepted start restarts the frame from any state; a zero-block start only
  // matters outside IDLE, where it aborts back to IDLE.
  assign accept      = start_of_frame && (blocks_per_frame != 32'd0);
  assign clear_all   = accept || (start_of_frame && (state != IDLE));
  assign all_means   = &(mean_seen | mean_ready);
  assign last_block  = (block_idx == bpf_q - 32'd1);
  assign last_sample = (cnt == LAST_CNT);
  assign flush_shift = &var_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept) state_next = READ_BLOCK;
      READ_BLOCK: if (pixel_valid && last_sample) state_next = WAIT_STATS;
      WAIT_STATS: if (all_means) state_next = last_block ? FLUSH : READ_BLOCK;
      FLUSH:      if (flush_shift && last_sample) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    if (start_of_frame && (state != IDLE)) state_next = accept ? READ_BLOCK : IDLE;
  end

  always_comb begin
    shift_en_1      = 1'b0;
    shift_en_2      = 1'b0;
    shift_en_mean   = '0;
    shift_reg_rst_n = 1'b1;
    frame_done      = 1'b0;
    busy            = (state != IDLE);
    if (clear_all) begin
      shift_en_1 = accept && pixel_valid;
      shift_en_2 = accept && pixel_valid;
    end else begin
      case (state)
        IDLE:       shift_reg_rst_n = 1'b0;
        READ_BLOCK: begin
          shift_en_1 = pixel_valid;
          shift_en_2 = pixel_valid;
        end
        WAIT_STATS: shift_en_mean = mean_ready & ~mean_seen;
        FLUSH:      shift_en_2 = flush_shift;
        DONE:       frame_done = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt                    <= '0;
      mean_seen              <= '0;
      var_seen               <= '0;
      bpf_q                  <= '0;
      block_idx              <= '0;
      variance_start_of_data <= 1'b0;
      overrun_err            <= 1'b0;
    end else begin
      variance_start_of_data <= 1'b0;
      if (pixel_valid && !accept && (state == WAIT_STATS || state == FLUSH))
        overrun_err <= 1'b1;
      if (clear_all) begin
        bpf_q     <= blocks_per_frame;
        block_idx <= '0;
        cnt       <= (accept && pixel_valid) ? CNT_W'(1) : '0;
        mean_seen <= '0;
        var_seen  <= '0;
      end else begin
        case (state)
          READ_BLOCK: if (pixel_valid) begin
            if (last_sample) begin
              cnt       <= '0;
              mean_seen <= '0;
              var_seen  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_STATS: begin
            mean_seen <= mean_seen | mean_ready;
            if (all_means) begin
              variance_start_of_data <= 1'b1;
              if (!last_block) block_idx <= block_idx + 32'd1;
            end
          end
          FLUSH: begin
            var_seen <= var_seen | variance_ready;
            if (flush_shift) cnt <= last_sample ? '0 : cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wiener_block_stats_ctrl_mc.sv
// Directed vector bench for wiener_block_stats_ctrl_mc with TOTAL_SAMPLES=4, NUM_CH=3.
module tb_wiener_block_stats_ctrl_mc;

  logic        clk;
  logic        rst_n;
  logic        start_of_frame;
  logic        pixel_valid;
  logic [31:0] blocks_per_frame;
  logic [2:0]  mean_ready;
  logic [2:0]  variance_ready;
  logic        shift_en_1;
  logic        shift_en_2;
  logic [2:0]  shift_en_mean;
  logic        shift_reg_rst_n;
  logic        variance_start_of_data;
  logic [31:0] block_idx;
  logic        frame_done;
  logic        busy;
  logic        overrun_err;

  int n_pass  = 0;
  int n_total = 0;

  wiener_block_stats_ctrl_mc #(
    .DATA_WIDTH(8),
    .TOTAL_SAMPLES(4),
    .NUM_CH(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_of_frame(start_of_frame),
    .pixel_valid(pixel_valid),
    .blocks_per_frame(blocks_per_frame),
    .mean_ready(mean_ready),
    .variance_ready(variance_ready),
    .shift_en_1(shift_en_1),
    .shift_en_2(shift_en_2),
    .shift_en_mean(shift_en_mean),
    .shift_reg_rst_n(shift_reg_rst_n),
    .variance_start_of_data(variance_start_of_data),
    .block_idx(block_idx),
    .frame_done(frame_done),
    .busy(busy),
    .overrun_err(overrun_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs driven, outputs expected before the next edge.
  typedef struct {
    logic        sof;
    logic        pv;
    logic [31:0] bpf;
    logic [2:0]  mr;
    logic [2:0]  vr;
    logic        se1;
    logic        se2;
    logic [2:0]  sem;
    logic        srn;
    logic        vsod;
    logic [31:0] bidx;
    logic        fd;
    logic        busy;
    logic        ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input int sof, input int pv, input int bpf, input int mr,
                     input int vr, input int se1, input int se2, input int sem, input int srn,
                     input int vsod, input int bidx, input int fd, input int bsy, input int ovr);
    vec_t v;
    v.sof  = 1'(sof);
    v.pv   = 1'(pv);
    v.bpf  = 32'(bpf);
    v.mr   = 3'(mr);
    v.vr   = 3'(vr);
    v.se1  = 1'(se1);
    v.se2  = 1'(se2);
    v.sem  = 3'(sem);
    v.srn  = 1'(srn);
    v.vsod = 1'(vsod);
    v.bidx = 32'(bidx);
    v.fd   = 1'(fd);
    v.busy = 1'(bsy);
    v.ovr  = 1'(ovr);
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
  endtask

  task automatic chk_reset_values(input int row);
    chk("rst shift_en_1", row, 32'(shift_en_1), 32'd0);
    chk("rst shift_en_2", row, 32'(shift_en_2), 32'd0);
    chk("rst shift_en_mean", row, 32'(shift_en_mean), 32'd0);
    chk("rst shift_reg_rst_n", row, 32'(shift_reg_rst_n), 32'd0);
    chk("rst variance_start", row, 32'(variance_start_of_data), 32'd0);
    chk("rst block_idx", row, block_idx, 32'd0);
    chk("rst frame_done", row, 32'(frame_done), 32'd0);
    chk("rst busy", row, 32'(busy), 32'd0);
    chk("rst overrun_err", row, 32'(overrun_err), 32'd0);
  endtask

  // Driver: apply one record at posedge+1, compare at the falling edge, step a cycle.
  task automatic apply(input int idx);
    vec_t v;
    v = vecs[idx];
    start_of_frame   = v.sof;
    pixel_valid      = v.pv;
    blocks_per_frame = v.bpf;
    mean_ready       = v.mr;
    variance_ready   = v.vr;
    #4;
    chk("shift_en_1", idx, 32'(shift_en_1), 32'(v.se1));
    chk("shift_en_2", idx, 32'(shift_en_2), 32'(v.se2));
    chk("shift_en_mean", idx, 32'(shift_en_mean), 32'(v.sem));
    chk("shift_reg_rst_n", idx, 32'(shift_reg_rst_n), 32'(v.srn));
    chk("variance_start", idx, 32'(variance_start_of_data), 32'(v.vsod));
    chk("block_idx", idx, block_idx, v.bidx);
    chk("frame_done", idx, 32'(frame_done), 32'(v.fd));
    chk("busy", idx, 32'(busy), 32'(v.busy));
    chk("overrun_err", idx, 32'(overrun_err), 32'(v.ovr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  n sof pv bpf mr vr | se1 se2 sem srn vsod bidx fd busy ovr
    // Basic frame, two blocks
    add(1, 1, 1, 2, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 0);
    add(2, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 7, 0,  0, 0, 7, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 1, 0, 1, 0);
    add(1, 0, 1, 0, 0, 7,  1, 1, 0, 1, 0, 1, 0, 1, 0);
    add(2, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 1, 0, 1, 0);
    add(2, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 7, 0,  0, 0, 7, 1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 7,  0, 0, 0, 1, 0, 1, 0, 1, 0);
    add(4, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Staggered means with a repeat pulse, staggered variances
    add(1, 1, 1, 1, 0, 0,  1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 4, 0,  0, 0, 4, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 2, 0,  0, 0, 2, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 3,  0, 0, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(4, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Gapped input 1,0,1,1,0,1 then pixels during WAIT_STATS
    add(1, 1, 1, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(2, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 7, 0,  0, 0, 7, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 7,  0, 0, 0, 1, 1, 0, 0, 1, 1);
    add(4, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Abort in block 1 WAIT_STATS, then abort with zero blocks, then ignored start
    add(1, 1, 1, 2, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 1);
    add(3, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 7, 0,  0, 0, 7, 1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 1, 0, 1, 1);
    add(3, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 2, 0, 0,  0, 0, 0, 1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Two-block frame run up to the first FLUSH cycle
    add(1, 1, 1, 2, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 1);
    add(3, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 7, 0,  0, 0, 7, 1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 1, 0, 1, 1);
    add(3, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(1, 0, 0, 0, 7, 0,  0, 0, 7, 1, 0, 1, 0, 1, 1);

    rst_n            = 1'b0;
    start_of_frame   = 1'b0;
    pixel_valid      = 1'b0;
    blocks_per_frame = 32'd0;
    mean_ready       = 3'd0;
    variance_ready   = 3'd0;
    #3;
    chk_reset_values(-1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // First FLUSH cycle, then asynchronous reset between clock edges
    start_of_frame = 1'b0;
    pixel_valid    = 1'b0;
    mean_ready     = 3'd0;
    variance_ready = 3'd0;
    #3;
    chk("flush variance_start", -2, 32'(variance_start_of_data), 32'd1);
    chk("flush busy", -2, 32'(busy), 32'd1);
    chk("flush block_idx", -2, block_idx, 32'd1);
    chk("flush overrun_err", -2, 32'(overrun_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_values(-3);
    @(posedge clk);
    #1;
    chk_reset_values(-4);
    rst_n = 1'b1;
    #3;
    chk_reset_values(-5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
